// File: rtl/reset_seq_pkg.sv
`default_nettype none
// ============================================================================
// reset_seq_pkg
// Shared state type, counter width and cause-width helper for reset_sequencer.
// Rev 1.0
// ============================================================================
package reset_seq_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ASSERT  = 2'd1,
      RELEASE = 2'd2,
      DONE    = 2'd3
   } seq_state_t;

   localparam int unsigned c_cnt_w = 32;

   // Width of the cause field: one code per source plus the power-on code.
   function automatic int unsigned cw_f(input int unsigned nsrc);
      return $unsigned($clog2(nsrc + 1));
   endfunction

endpackage
`default_nettype wire

// File: rtl/reset_sequencer_req_edge_latch.sv
`default_nettype none
// ============================================================================
// req_edge_latch
// Registers reset requests, detects rising edges and holds them until acked.
// Rev 1.0
// ============================================================================
module req_edge_latch
   import reset_seq_pkg::*;
#(
   parameter int unsigned NSRC = 4
) (
   input  logic            Clk,
   input  logic            nRst,
   input  logic [NSRC-1:0] req,
   input  logic [NSRC-1:0] ack,
   output logic [NSRC-1:0] pending
);

   logic [NSRC-1:0] r_req;
   logic [NSRC-1:0] r_req_d;
   logic [NSRC-1:0] r_pending;

   // A fresh edge wins over a simultaneous ack so the new request is kept.
   always_ff @(posedge Clk or negedge nRst) begin
      if (!nRst) begin
         r_req     <= '0;
         r_req_d   <= '0;
         r_pending <= '0;
      end else begin
         r_req     <= req;
         r_req_d   <= r_req;
         r_pending <= (r_pending & ~ack) | (r_req & ~r_req_d);
      end
   end

   assign pending = r_pending;

endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// reset_sequencer
// Arbitrates reset requests and drives a timed, ordered multi-domain reset.
// Rev 1.0
// ============================================================================
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int unsigned NSRC      = 4,
   parameter int unsigned NDOM      = 3,
   parameter int unsigned PULSE_CYC = 200000000,
   parameter int unsigned GAP_CYC   = 1000
) (
   input  logic                    Clk,
   input  logic                    nRst,
   input  logic [NSRC-1:0]         req,
   output logic [NSRC-1:0]         ack,
   output logic [NDOM-1:0]         dom_rst,
   output logic                    busy,
   output logic                    done,
   output logic [cw_f(NSRC)-1:0]   cause
);

   localparam int unsigned CW = cw_f(NSRC);
   localparam int unsigned KW = $clog2(NDOM + 1);
   localparam logic [c_cnt_w-1:0] c_pulse_last = c_cnt_w'(PULSE_CYC - 1);
   localparam logic [c_cnt_w-1:0] c_gap_last   = c_cnt_w'(GAP_CYC - 1);

   seq_state_t         r_state;
   seq_state_t         w_state_nxt;
   logic [c_cnt_w-1:0] r_cnt;
   logic [c_cnt_w-1:0] w_cnt_nxt;
   logic [KW-1:0]      r_k;
   logic [KW-1:0]      w_k_nxt;
   logic [NDOM-1:0]    r_dom_rst;
   logic [NDOM-1:0]    w_dom_nxt;
   logic [CW-1:0]      r_cause;
   logic [CW-1:0]      w_cause_nxt;
   logic [NSRC-1:0]    w_pending;
   logic [CW-1:0]      w_grant_idx;
   logic               w_any;

   req_edge_latch #(
      .NSRC (NSRC)
   ) u_req_edge_latch (
      .Clk     (Clk),
      .nRst    (nRst),
      .req     (req),
      .ack     (ack),
      .pending (w_pending)
   );

   // Fixed priority: lowest set index wins.
   always_comb begin
      w_any       = |w_pending;
      w_grant_idx = '0;
      for (int i = int'(NSRC) - 1; i >= 0; i--) begin
         if (w_pending[i]) w_grant_idx = CW'(i);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_k_nxt     = r_k;
      w_dom_nxt   = r_dom_rst;
      w_cause_nxt = r_cause;
      ack         = '0;
      busy        = 1'b0;
      done        = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_any) begin
               ack         = NSRC'(1) << w_grant_idx;
               w_state_nxt = ASSERT;
               w_cnt_nxt   = '0;
               w_dom_nxt   = '1;
               w_cause_nxt = w_grant_idx;
            end
         end
         ASSERT: begin
            busy = 1'b1;
            if (r_cnt == c_pulse_last) begin
               w_state_nxt  = RELEASE;
               w_cnt_nxt    = '0;
               w_dom_nxt[0] = 1'b0;
               w_k_nxt      = KW'(1);
            end else begin
               w_cnt_nxt = r_cnt + c_cnt_w'(1);
            end
         end
         RELEASE: begin
            busy = 1'b1;
            // One extra RELEASE cycle after the last domain drops, then DONE.
            if (r_k == KW'(NDOM)) begin
               w_state_nxt = DONE;
            end else if (r_cnt == c_gap_last) begin
               w_cnt_nxt = '0;
               w_k_nxt   = r_k + KW'(1);
               for (int i = 1; i < int'(NDOM); i++) begin
                  if (r_k == KW'(i)) w_dom_nxt[i] = 1'b0;
               end
            end else begin
               w_cnt_nxt = r_cnt + c_cnt_w'(1);
            end
         end
         DONE: begin
            done        = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge nRst) begin
      if (!nRst) begin
         r_state   <= ASSERT;
         r_cnt     <= '0;
         r_k       <= '0;
         r_dom_rst <= '1;
         r_cause   <= CW'(NSRC);
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_k       <= w_k_nxt;
         r_dom_rst <= w_dom_nxt;
         r_cause   <= w_cause_nxt;
      end
   end

   assign dom_rst = r_dom_rst;
   assign cause   = r_cause;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_reset_sequencer
// Directed self-checking bench for reset_sequencer (P=8, GAP=3, 3 domains).
// Rev 1.0
// ============================================================================
module tb_reset_sequencer;

   localparam int NSRC = 4;
   localparam int NDOM = 3;
   localparam int P    = 8;
   localparam int GAP  = 3;
   localparam int DLEN = 2 + P + (NDOM - 1) * GAP;
   localparam int NONE = 100000;

   logic       Clk  = 1'b0;
   logic       nRst = 1'b0;
   logic [3:0] req  = 4'b0;
   logic [3:0] ack;
   logic [2:0] dom_rst;
   logic       busy;
   logic       done;
   logic [2:0] cause;

   int         checks = 0;
   int         errors = 0;
   logic [2:0] last_cause;
   logic [11:0] obs;
   logic [11:0] exp;

   reset_sequencer #(
      .NSRC      (NSRC),
      .NDOM      (NDOM),
      .PULSE_CYC (P),
      .GAP_CYC   (GAP)
   ) dut (
      .Clk     (Clk),
      .nRst    (nRst),
      .req     (req),
      .ack     (ack),
      .dom_rst (dom_rst),
      .busy    (busy),
      .done    (done),
      .cause   (cause)
   );

   always #5 Clk = ~Clk;

   // Expected {dom_rst, busy, done, ack, cause} at cycle c for up to two grants.
   function automatic logic [11:0] model(int c, int g1, logic [3:0] a1, logic [2:0] k1,
                                         int g2, logic [3:0] a2, logic [2:0] k2,
                                         logic [2:0] prev);
      int         g;
      logic [2:0] d;
      logic       b;
      logic       dn;
      logic [3:0] a;
      logic [2:0] cs;
      g  = (c <= g1 + DLEN) ? g1 : g2;
      d  = 3'b000;
      if (c >= g + 1)
         for (int k = 0; k < NDOM; k++) d[k] = (c < g + 1 + P + k * GAP);
      b  = (c >= g + 1) && (c < g + DLEN);
      dn = (c == g + DLEN);
      a  = 4'b0;
      if (c == g1) a = a1;
      if (c == g2) a = a2;
      cs = (c > g2) ? k2 : (c > g1) ? k1 : prev;
      return {d, b, dn, a, cs};
   endfunction

   task automatic test_reset();
      for (int c = 0; c < 3; c++) begin
         @(negedge Clk);
         #1;
         obs = {dom_rst, busy, done, ack, cause};
         checks++;
         if (obs !== 12'b111_1_0_0000_100) begin
            errors++;
            $display("FAIL reset c=%0d got %b exp %b", c, obs, 12'b111_1_0_0000_100);
         end
      end
   endtask

   task automatic test_power_on();
      for (int c = 0; c <= 18; c++) begin
         @(negedge Clk);
         if (c == 0) nRst = 1'b1;
         #1;
         obs = {dom_rst, busy, done, ack, cause};
         exp = model(c, -1, 4'b0, 3'd4, NONE, 4'b0, 3'd0, 3'd4);
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL power_on c=%0d got %b exp %b", c, obs, exp);
         end
      end
      last_cause = 3'd4;
   endtask

   task automatic test_single();
      for (int c = 0; c <= 20; c++) begin
         @(negedge Clk);
         req = (c == 0) ? 4'b0100 : 4'b0000;
         #1;
         obs = {dom_rst, busy, done, ack, cause};
         exp = model(c, 2, 4'b0100, 3'd2, NONE, 4'b0, 3'd0, last_cause);
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL single c=%0d got %b exp %b", c, obs, exp);
         end
      end
      last_cause = 3'd2;
   endtask

   task automatic test_priority();
      for (int c = 0; c <= 37; c++) begin
         @(negedge Clk);
         req = (c == 0) ? 4'b1010 : 4'b0000;
         #1;
         obs = {dom_rst, busy, done, ack, cause};
         exp = model(c, 2, 4'b0010, 3'd1, 2 + DLEN + 1, 4'b1000, 3'd3, last_cause);
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL priority c=%0d got %b exp %b", c, obs, exp);
         end
      end
      last_cause = 3'd3;
   endtask

   task automatic test_busy_request();
      for (int c = 0; c <= 37; c++) begin
         @(negedge Clk);
         req = (c == 0) ? 4'b1000 : (c == 12) ? 4'b0001 : 4'b0000;
         #1;
         obs = {dom_rst, busy, done, ack, cause};
         exp = model(c, 2, 4'b1000, 3'd3, 2 + DLEN + 1, 4'b0001, 3'd0, last_cause);
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL busy_request c=%0d got %b exp %b", c, obs, exp);
         end
      end
      last_cause = 3'd0;
   endtask

   task automatic test_level_hold();
      for (int c = 0; c <= 110; c++) begin
         @(negedge Clk);
         req = (c < 100) ? 4'b0010 : 4'b0000;
         #1;
         obs = {dom_rst, busy, done, ack, cause};
         exp = model(c, 2, 4'b0010, 3'd1, NONE, 4'b0, 3'd0, last_cause);
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL level_hold c=%0d got %b exp %b", c, obs, exp);
         end
      end
      last_cause = 3'd1;
   endtask

   task automatic test_re_edge();
      for (int c = 0; c <= 60; c++) begin
         @(negedge Clk);
         req = (c < 5 || (c >= 7 && c < 50)) ? 4'b0010 : 4'b0000;
         #1;
         obs = {dom_rst, busy, done, ack, cause};
         exp = model(c, 2, 4'b0010, 3'd1, 2 + DLEN + 1, 4'b0010, 3'd1, last_cause);
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL re_edge c=%0d got %b exp %b", c, obs, exp);
         end
      end
      last_cause = 3'd1;
   endtask

   task automatic test_mid_reset();
      for (int c = 0; c <= 34; c++) begin
         @(negedge Clk);
         req = (c == 0) ? 4'b0100 : (c == 5) ? 4'b0001 : 4'b0000;
         if (c == 12) nRst = 1'b0;
         if (c == 14) nRst = 1'b1;
         #1;
         obs = {dom_rst, busy, done, ack, cause};
         if (c < 12)
            exp = model(c, 2, 4'b0100, 3'd2, NONE, 4'b0, 3'd0, last_cause);
         else if (c < 14)
            exp = 12'b111_1_0_0000_100;
         else
            exp = model(c - 14, -1, 4'b0, 3'd4, NONE, 4'b0, 3'd0, 3'd4);
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL mid_reset c=%0d got %b exp %b", c, obs, exp);
         end
      end
      last_cause = 3'd4;
   endtask

   initial begin
      last_cause = 3'd4;
      test_reset();
      test_power_on();
      test_single();
      test_priority();
      test_busy_request();
      test_level_hold();
      test_re_edge();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/reset_sequencer.md
# reset_sequencer

Central reset controller for the encoder tester. It accepts reset requests from several independent sources (host command, watchdog, encoder-fault logic, front-panel button), and arbitrates them with fixed priority. For each granted request it drives one timed, ordered reset sequence across several logic domains. It replaces ad-hoc single-pulse reset generation and reports the cause of the last reset to the host register block.

## Interface

Parameters:
- NSRC, 4: number of request sources.
- NDOM, 3: number of reset domains, released in index order.
- PULSE_CYC, 200000000: cycles all domains are held in reset (≥1, fits 32 bits).
- GAP_CYC, 1000: cycles between successive domain releases (≥1, fits 32 bits).

Ports:
- Clk, in, 1: system clock. All logic is on the rising edge.
- nRst, in, 1: asynchronous, active-low reset.
- req, in, NSRC: reset requests, edge-triggered per bit.
- ack, out, NSRC: one-hot, one-cycle grant pulse.
- dom_rst, out, NDOM: active-high domain resets.
- busy, out, 1: high while a sequence is in progress.
- done, out, 1: one-cycle pulse when a sequence completes.
- cause, out, CW = clog2(NSRC+1): source index of the last granted sequence. The value NSRC means power-on.

## Operation

- Request latching:
  - req is registered once, and a rising edge (0→1 between consecutive samples) on bit i sets pending[i].
  - pending[i] clears only in the cycle ack[i] is asserted.
  - If a new rising edge on bit i coincides with ack[i], pending[i] stays set.
  - Edges that occur while busy are latched and serviced after the current sequence.
- Arbitration: in IDLE, the lowest set index of pending wins. ack of the winner pulses, cause is loaded with the index, and the state moves to ASSERT.
- States:
  - IDLE: dom_rst=0, busy=0. Go to ASSERT when any pending bit is set.
  - ASSERT: dom_rst all 1, busy=1. The 32-bit counter runs from 0. After PULSE_CYC cycles in ASSERT, domain 0 is released, the counter clears, and the state moves to RELEASE.
  - RELEASE: index k starts at 1. Every GAP_CYC cycles, dom_rst[k] goes to 0 and k increments. Once all NDOM domains are released, go to DONE.
  - DONE: busy=0, done=1 for one cycle, then go to IDLE. Arbitration is not evaluated in DONE.
- Released domains stay 0. Domains are never re-asserted inside a sequence.
- cause holds its value until the next grant.

## Timing

- Reset values (nRst low, asynchronous): dom_rst all 1, busy=1, done=0, ack=0, cause=NSRC, pending=0, counter=0, state=ASSERT.
  - Release of nRst therefore runs a full power-on sequence with no request required.
  - Asserting nRst mid-sequence aborts it immediately, and pending requests are lost.
- Grant at cycle G (ack high in G, pending sampled in G):
  - dom_rst all 1 from G+1.
  - dom_rst[k] falls at G+1+PULSE_CYC+k·GAP_CYC.
  - done is high in cycle D = G+2+PULSE_CYC+(NDOM-1)·GAP_CYC.
- The earliest next grant is D+1.
- A req edge at cycle t appears in pending at t+2 (one register stage, one edge/latch stage).
- Simultaneous edges on several bits are all latched, then served in index order, one sequence each.

## Structure

- Package reset_seq_pkg holds:
  - the state enum (IDLE, ASSERT, RELEASE, DONE);
  - the counter width constant (32);
  - a function for CW.
- Sub-module req_edge_latch is natural. It contains the NSRC-wide input register, rising-edge detect and the pending register with clear-by-ack.
- The top level holds arbitration, the FSM, the counter and the outputs.

## Test plan

All scenarios use NSRC=4, NDOM=3, PULSE_CYC=8, GAP_CYC=3.

- Power-on: release nRst at cycle 0.
  - dom_rst=111 through cycle 7, then 110 at 8, 100 at 11, 000 at 14.
  - done at 15; cause=4 throughout.
- Single request: pulse req[2] for 1 cycle while IDLE.
  - ack[2] pulses 2 cycles later at G.
  - dom_rst timeline matches the formulas with G.
  - cause=2 from G+1; done at G+16.
- Priority: raise req[3] and req[1] in the same cycle.
  - Sequence for 1 first (ack[1]), then for 3, with ack[3] at the cycle after the first done.
- Request during busy: pulse req[0] mid-RELEASE.
  - No disturbance to the current sequence.
  - ack[0] comes the cycle after done, followed by a second full sequence.
- Level hold and re-edge:
  - req[1] held high for 100 cycles: exactly one sequence.
  - Dropping and re-raising req[1] while busy: exactly one additional sequence.
- Mid-operation reset: assert nRst at G+10.
  - dom_rst=111, busy=1, cause=4 immediately.
  - After release, a full power-on sequence runs and the earlier pending bits are cleared.
